// File: rtl/instruction_sequencer.sv
// instruction_sequencer: preloadable program buffer that issues one CPU instruction per clock,
// padding each tensor-core operate with NOP bubbles. Optional macro SEQUENCER_LOOP_EN enables looping with stop_in.
module instruction_sequencer #(
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned TENSOR_WAIT_CYCLES = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     load_valid_in,
  output logic                     load_ready_out,
  input  logic [31:0]              load_instruction_in,
  input  logic                     clear_in,
  input  logic                     start_in,
`ifdef SEQUENCER_LOOP_EN
  input  logic                     stop_in,
`endif
  output logic [31:0]              current_instruction_out,
  output logic                     instruction_valid_out,
  output logic [$clog2(DEPTH)-1:0] pc_out,
  output logic [$clog2(DEPTH):0]   program_length_out,
  output logic                     busy_out,
  output logic                     done_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(TENSOR_WAIT_CYCLES + 2);
  localparam logic [7:0]  OP_TENSOR = 8'h05;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0008;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [31:0]     instr_d;
  logic            valid_d, busy_d, done_d, ready_d;
  logic            wr_en;
  logic            is_last;
  logic            end_pass;
  logic [31:0]     rd_word;
  logic [31:0]     mem [DEPTH];

  assign rd_word            = mem[pc_q];
  assign pc_out             = pc_q;
  assign program_length_out = len_q;

`ifdef SEQUENCER_LOOP_EN
  logic stop_q;

  // Sticky stop request, cleared whenever the sequencer is idle.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)                                stop_q <= 1'b0;
    else if (state_q == S_IDLE)                     stop_q <= 1'b0;
    else if (stop_in && (state_q == S_RUN || state_q == S_WAIT)) stop_q <= 1'b1;
  end

  assign end_pass = stop_q | stop_in;
`else
  assign end_pass = 1'b1;
`endif

  // Program RAM, intentionally not reset.
  always_ff @(posedge clock_in) begin
    if (wr_en) mem[len_q[PW-1:0]] <= load_instruction_in;
  end

  // State and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q                 <= S_IDLE;
      pc_q                    <= '0;
      len_q                   <= '0;
      cnt_q                   <= '0;
      last_q                  <= 1'b0;
      current_instruction_out <= NOP_WORD;
      instruction_valid_out   <= 1'b0;
      busy_out                <= 1'b0;
      done_out                <= 1'b0;
      load_ready_out          <= 1'b1;
    end else begin
      state_q                 <= state_d;
      pc_q                    <= pc_d;
      len_q                   <= len_d;
      cnt_q                   <= cnt_d;
      last_q                  <= last_d;
      current_instruction_out <= instr_d;
      instruction_valid_out   <= valid_d;
      busy_out                <= busy_d;
      done_out                <= done_d;
      load_ready_out          <= ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    is_last = ({1'b0, pc_q} == (len_q - LW'(1)));

    unique case (state_q)
      S_IDLE: begin
        if (clear_in) begin
          len_d = '0;
        end else if (load_valid_in && load_ready_out) begin
          wr_en = 1'b1;
          len_d = len_q + LW'(1);
        end
        // A load in the same cycle as start becomes part of the program.
        if (start_in && (len_d != '0)) begin
          pc_d    = '0;
          last_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        instr_d = rd_word;
        valid_d = 1'b1;
        pc_d    = pc_q + PW'(1);
        if ((rd_word[7:0] == OP_TENSOR) && (TENSOR_WAIT_CYCLES != 0)) begin
          state_d = S_WAIT;
          cnt_d   = CW'(TENSOR_WAIT_CYCLES);
          last_d  = is_last;
        end else if (is_last) begin
          if (end_pass) state_d = S_DONE;
          else          pc_d    = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!last_q) begin
            state_d = S_RUN;
          end else if (end_pass) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            pc_d    = '0;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pc_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_q == S_RUN) || (state_q == S_WAIT);
    ready_d = (state_d == S_IDLE) && (len_d < LW'(DEPTH));
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer (default build, DEPTH=16, TENSOR_WAIT_CYCLES=4).
module tb_instruction_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0008;
  localparam logic [31:0] WA  = 32'h0100_0009;
  localparam logic [31:0] WB  = 32'h0201_0500;
  localparam logic [31:0] WC  = 32'h0000_0001;
  localparam logic [31:0] WD  = 32'h0300_0006;
  localparam logic [31:0] WE  = 32'h0000_0005;
  localparam logic [31:0] WF  = 32'h0403_0200;
  localparam logic [31:0] WG  = 32'h0705_0300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv = 1'b0;
  logic        ready;
  logic [31:0] lw = '0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr;
  logic        valid;
  logic [3:0]  pc;
  logic [4:0]  len;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.DEPTH(16), .TENSOR_WAIT_CYCLES(4)) dut (
    .clock_in                (clk),
    .reset_n_in              (rst_n),
    .load_valid_in           (lv),
    .load_ready_out          (ready),
    .load_instruction_in     (lw),
    .clear_in                (clear),
    .start_in                (start),
`ifdef SEQUENCER_LOOP_EN
    .stop_in                 (1'b0),
`endif
    .current_instruction_out (instr),
    .instruction_valid_out   (valid),
    .pc_out                  (pc),
    .program_length_out      (len),
    .busy_out                (busy),
    .done_out                (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_instr, input logic e_valid,
                         input logic e_busy, input logic e_done);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  task automatic load(input logic [31:0] w, input int exp_len);
    lv = 1'b1;
    lw = w;
    tick();
    lv = 1'b0;
    chk("load.len", 32'(len), 32'(exp_len));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear.len", 32'(len), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_i [9];
    logic        exp_v [9];
    logic        exp_b [9];
    logic        exp_d [9];

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", NOP, 1'b0, 1'b0, 1'b0);
    chk("reset.pc", 32'(pc), 32'd0);
    chk("reset.len", 32'(len), 32'd0);
    chk("reset.ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Three-word program, no operates
    load(WA, 1);
    load(WB, 2);
    load(WC, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t1.start", NOP, 1'b0, 1'b0, 1'b0);
    chk("t1.ready_run", 32'(ready), 32'd0);
    tick(); chk_out("t1.w0", WA, 1'b1, 1'b1, 1'b0);
    chk("t1.pc1", 32'(pc), 32'd1);
    tick(); chk_out("t1.w1", WB, 1'b1, 1'b1, 1'b0);
    tick(); chk_out("t1.w2", WC, 1'b1, 1'b1, 1'b0);
    tick(); chk_out("t1.done", NOP, 1'b0, 1'b0, 1'b1);
    chk("t1.pc0", 32'(pc), 32'd0);
    chk("t1.ready_idle", 32'(ready), 32'd1);
    tick(); chk_out("t1.idle", NOP, 1'b0, 1'b0, 1'b0);

    // Replay of the same buffer
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); chk_out("replay.w0", WA, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_out("replay.done", NOP, 1'b0, 1'b0, 1'b1);

    // LOAD, OPERATE (4 bubbles), ADD
    do_clear();
    load(WD, 1);
    load(WE, 2);
    load(WF, 3);
    exp_i = '{WD, WE, NOP, NOP, NOP, NOP, WF, NOP, NOP};
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_out($sformatf("t2.c%0d", k), exp_i[k], exp_v[k], exp_b[k], exp_d[k]);
      if (k == 1) chk("t2.pc_after_op", 32'(pc), 32'd2);
    end

    // Fill to DEPTH with valid held high; 17th word refused
    do_clear();
    lv = 1'b1;
    for (int i = 0; i < 17; i++) begin
      lw = {8'(i), 24'h000000};
      tick();
      chk($sformatf("fill.len%0d", i), 32'(len), (i < 16) ? 32'(i + 1) : 32'd16);
      chk($sformatf("fill.ready%0d", i), 32'(ready), (i < 15) ? 32'd1 : 32'd0);
    end
    lv = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("full.w%0d", k), instr, {8'(k), 24'h000000});
    end
    tick(); chk_out("full.done", NOP, 1'b0, 1'b0, 1'b1);

    // Clear and load in the same cycle with length 5: clear wins
    do_clear();
    for (int i = 0; i < 5; i++) load(32'h0000_0100 * 32'(i + 1), i + 1);
    clear = 1'b1;
    lv    = 1'b1;
    lw    = 32'hDEAD_0005;
    tick();
    clear = 1'b0;
    lv    = 1'b0;
    chk("clrld.len", 32'(len), 32'd0);
    chk("clrld.ready", 32'(ready), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clrld.ready_after_start", 32'(ready), 32'd1);
    tick(); chk_out("clrld.ignored", NOP, 1'b0, 1'b0, 1'b0);

    // Load coinciding with start joins the program
    lv    = 1'b1;
    lw    = WG;
    start = 1'b1;
    tick();
    lv    = 1'b0;
    start = 1'b0;
    chk("ldst.len", 32'(len), 32'd1);
    tick(); chk_out("ldst.w0", WG, 1'b1, 1'b1, 1'b0);
    tick(); chk_out("ldst.done", NOP, 1'b0, 1'b0, 1'b1);

    // Reset asserted during WAIT aborts the run
    do_clear();
    load(WD, 1);
    load(WE, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_out("rstw.pre", NOP, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("rstw.async", NOP, 1'b0, 1'b0, 1'b0);
    chk("rstw.len", 32'(len), 32'd0);
    chk("rstw.ready", 32'(ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); chk_out("rstw.start_ignored", NOP, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("rstw.still_idle", NOP, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
